// File: rtl/regfile_wb_seq.sv
// rtl/regfile_wb_seq.sv - two-cycle 16-bit writeback sequencer with size/extension formatting

package typedefs;
    typedef enum logic [1:0] {
        SIZE_W   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_B   = 2'd2,
        SIZE_BIT = 2'd3
    } cs_size;

    typedef enum logic {
        EXT_Z = 1'b0,
        EXT_S = 1'b1
    } cs_ext;
endpackage

module regfile_wb_seq
    import typedefs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_rd_i,
    input  logic [31:0] in_data_i,
    input  cs_size      in_size_i,
    input  cs_ext       in_ext_i,
    input  logic [1:0]  in_off_i,
    output logic        wr_o,
    output logic [4:0]  wr_rd_o,
    output logic        wr_h_sel_o,
    output logic [15:0] wr_data_o,
    output logic        busy_o,
    output logic [4:0]  busy_rd_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  rd_q;
    logic [15:0] lo_q;
    logic [15:0] hi_q;
    logic        xfer;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_b;
    logic        sign_h;
    logic [15:0] fmt_lo;
    logic [15:0] fmt_hi;

    // Ready only depends on state so upstream never sees a loop through in_valid_i.
    assign in_ready_o = (state_q == ST_IDLE) || (state_q == ST_HIGH);
    assign xfer       = in_valid_i && in_ready_o;

    // Slice and extend the incoming word into the two halves the register file will see.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        fmt_lo   = 16'h0000;
        fmt_hi   = 16'h0000;
        case (in_off_i)
            2'd0:    byte_sel = in_data_i[7:0];
            2'd1:    byte_sel = in_data_i[15:8];
            2'd2:    byte_sel = in_data_i[23:16];
            default: byte_sel = in_data_i[31:24];
        endcase
        half_sel = in_off_i[1] ? in_data_i[31:16] : in_data_i[15:0];
        sign_b   = (in_ext_i == EXT_S) && byte_sel[7];
        sign_h   = (in_ext_i == EXT_S) && half_sel[15];
        case (in_size_i)
            SIZE_H: begin
                fmt_lo = half_sel;
                fmt_hi = {16{sign_h}};
            end
            SIZE_B: begin
                fmt_lo = {{8{sign_b}}, byte_sel};
                fmt_hi = {16{sign_b}};
            end
            SIZE_BIT: begin
                fmt_lo = {15'b0, in_data_i[0]};
                fmt_hi = 16'h0000;
            end
            default: begin
                // Word, and any unknown size encoding, passes straight through.
                fmt_lo = in_data_i[15:0];
                fmt_hi = in_data_i[31:16];
            end
        endcase
    end

    // State register; reset aborts any in-flight write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: LOW always hands off to HIGH, HIGH can chain straight into a new LOW.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = xfer ? ST_LOW : ST_IDLE;
            ST_LOW:  state_d = ST_HIGH;
            ST_HIGH: state_d = xfer ? ST_LOW : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the formatted halves and rd on a transfer; HIGH keeps its value until its edge ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= 5'd0;
            lo_q <= 16'h0000;
            hi_q <= 16'h0000;
        end else if (xfer) begin
            rd_q <= in_rd_i;
            lo_q <= fmt_lo;
            hi_q <= fmt_hi;
        end
    end

    // Write-port and hazard outputs are pure decodes of registered state.
    always_comb begin
        wr_o       = 1'b0;
        wr_rd_o    = 5'd0;
        wr_h_sel_o = 1'b0;
        wr_data_o  = 16'h0000;
        busy_o     = 1'b0;
        busy_rd_o  = 5'd0;
        case (state_q)
            ST_LOW: begin
                wr_o      = (rd_q != 5'd0);
                wr_rd_o   = rd_q;
                wr_data_o = lo_q;
                busy_o    = 1'b1;
                busy_rd_o = rd_q;
            end
            ST_HIGH: begin
                wr_o       = (rd_q != 5'd0);
                wr_rd_o    = rd_q;
                wr_h_sel_o = 1'b1;
                wr_data_o  = hi_q;
                busy_o     = 1'b1;
                busy_rd_o  = rd_q;
            end
            default: begin
                wr_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_wb_seq.sv
// tb/tb_regfile_wb_seq.sv - directed self-checking bench for regfile_wb_seq

module tb_regfile_wb_seq;
    import typedefs::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [4:0]  in_rd_i;
    logic [31:0] in_data_i;
    cs_size      in_size_i;
    cs_ext       in_ext_i;
    logic [1:0]  in_off_i;
    logic        wr_o;
    logic [4:0]  wr_rd_o;
    logic        wr_h_sel_o;
    logic [15:0] wr_data_o;
    logic        busy_o;
    logic [4:0]  busy_rd_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [29:0] obs;
    assign obs = {wr_o, wr_rd_o, wr_h_sel_o, wr_data_o, busy_o, busy_rd_o, in_ready_o};

    regfile_wb_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_rd_i    (in_rd_i),
        .in_data_i  (in_data_i),
        .in_size_i  (in_size_i),
        .in_ext_i   (in_ext_i),
        .in_off_i   (in_off_i),
        .wr_o       (wr_o),
        .wr_rd_o    (wr_rd_o),
        .wr_h_sel_o (wr_h_sel_o),
        .wr_data_o  (wr_data_o),
        .busy_o     (busy_o),
        .busy_rd_o  (busy_rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] pack(logic wr, logic [4:0] rd, logic hs, logic [15:0] d,
                                         logic b, logic [4:0] brd, logic rdy);
        return {wr, rd, hs, d, b, brd, rdy};
    endfunction

    localparam logic [29:0] IDLE_V = 30'h1;

    task automatic drive(logic v, logic [4:0] rd, logic [31:0] d, cs_size s, cs_ext e, logic [1:0] o);
        in_valid_i = v;
        in_rd_i    = rd;
        in_data_i  = d;
        in_size_i  = s;
        in_ext_i   = e;
        in_off_i   = o;
    endtask

    task automatic run_one(string name, logic [4:0] rd, logic [31:0] d, cs_size s, cs_ext e,
                           logic [1:0] o, logic [15:0] exp_lo, logic [15:0] exp_hi);
        logic [29:0] exp;
        @(posedge clk); #1;
        drive(1'b1, rd, d, s, e, o);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, SIZE_W, EXT_Z, 2'd0);
        exp = pack(rd != 5'd0, rd, 1'b0, exp_lo, 1'b1, rd, 1'b0);
        check_cnt++;
        if (obs !== exp) $display("FAIL %s_low actual=%h expected=%h", name, obs, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        exp = pack(rd != 5'd0, rd, 1'b1, exp_hi, 1'b1, rd, 1'b1);
        check_cnt++;
        if (obs !== exp) $display("FAIL %s_high actual=%h expected=%h", name, obs, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        check_cnt++;
        if (obs !== IDLE_V) $display("FAIL %s_idle actual=%h expected=%h", name, obs, IDLE_V);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, SIZE_W, EXT_Z, 2'd0);
        #1;
        check_cnt++;
        if (obs !== IDLE_V) $display("FAIL reset_during actual=%h expected=%h", obs, IDLE_V);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_cnt++;
        if (obs !== IDLE_V) $display("FAIL reset_after actual=%h expected=%h", obs, IDLE_V);
        else pass_cnt++;
    endtask

    task automatic test_size_w();
        run_one("w_deadbeef", 5'd5, 32'hDEAD_BEEF, SIZE_W, EXT_S, 2'd3, 16'hBEEF, 16'hDEAD);
    endtask

    task automatic test_size_b();
        run_one("b_sext_off2", 5'd7, 32'h0080_0000, SIZE_B, EXT_S, 2'd2, 16'hFF80, 16'hFFFF);
        run_one("b_zext_off2", 5'd7, 32'h0080_0000, SIZE_B, EXT_Z, 2'd2, 16'h0080, 16'h0000);
        run_one("b_sext_off3_pos", 5'd8, 32'h7F00_0000, SIZE_B, EXT_S, 2'd3, 16'h007F, 16'h0000);
        run_one("b_zext_off1", 5'd9, 32'h0000_AB00, SIZE_B, EXT_Z, 2'd1, 16'h00AB, 16'h0000);
    endtask

    task automatic test_size_h();
        run_one("h_zext_off2", 5'd10, 32'h9234_5678, SIZE_H, EXT_Z, 2'd2, 16'h9234, 16'h0000);
        run_one("h_sext_off2", 5'd10, 32'h9234_5678, SIZE_H, EXT_S, 2'd2, 16'h9234, 16'hFFFF);
        run_one("h_sext_off0", 5'd11, 32'h0000_8001, SIZE_H, EXT_S, 2'd0, 16'h8001, 16'hFFFF);
    endtask

    task automatic test_size_bit();
        run_one("bit_zero", 5'd12, 32'hFFFF_FFFE, SIZE_BIT, EXT_S, 2'd0, 16'h0000, 16'h0000);
        run_one("bit_one", 5'd12, 32'h0000_0001, SIZE_BIT, EXT_Z, 2'd0, 16'h0001, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic [29:0] exp_seq [7];
        exp_seq[0] = pack(1'b1, 5'd3, 1'b0, 16'h2222, 1'b1, 5'd3, 1'b0);
        exp_seq[1] = pack(1'b1, 5'd3, 1'b1, 16'h1111, 1'b1, 5'd3, 1'b1);
        exp_seq[2] = pack(1'b0, 5'd0, 1'b0, 16'h6666, 1'b1, 5'd0, 1'b0);
        exp_seq[3] = pack(1'b0, 5'd0, 1'b1, 16'h5555, 1'b1, 5'd0, 1'b1);
        exp_seq[4] = pack(1'b1, 5'd4, 1'b0, 16'h4444, 1'b1, 5'd4, 1'b0);
        exp_seq[5] = pack(1'b1, 5'd4, 1'b1, 16'h3333, 1'b1, 5'd4, 1'b1);
        exp_seq[6] = IDLE_V;
        @(posedge clk); #1;
        drive(1'b1, 5'd3, 32'h1111_2222, SIZE_W, EXT_Z, 2'd0);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            check_cnt++;
            if (obs !== exp_seq[c])
                $display("FAIL b2b_cycle%0d actual=%h expected=%h", c + 1, obs, exp_seq[c]);
            else pass_cnt++;
            if (c == 0) drive(1'b1, 5'd0, 32'h5555_6666, SIZE_W, EXT_Z, 2'd0);
            if (c == 2) drive(1'b1, 5'd4, 32'h3333_4444, SIZE_W, EXT_Z, 2'd0);
            if (c == 4) drive(1'b0, 5'd0, 32'h0, SIZE_W, EXT_Z, 2'd0);
        end
    endtask

    task automatic test_reset_mid();
        logic [29:0] exp;
        @(posedge clk); #1;
        drive(1'b1, 5'd9, 32'h1234_5678, SIZE_W, EXT_Z, 2'd0);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, SIZE_W, EXT_Z, 2'd0);
        exp = pack(1'b1, 5'd9, 1'b0, 16'h5678, 1'b1, 5'd9, 1'b0);
        check_cnt++;
        if (obs !== exp) $display("FAIL rstmid_low actual=%h expected=%h", obs, exp);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (obs !== IDLE_V) $display("FAIL rstmid_async actual=%h expected=%h", obs, IDLE_V);
        else pass_cnt++;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check_cnt++;
            if (obs !== IDLE_V)
                $display("FAIL rstmid_post%0d actual=%h expected=%h", c, obs, IDLE_V);
            else pass_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_size_w();
        test_size_b();
        test_size_h();
        test_size_bit();
        test_back_to_back();
        test_reset_mid();
        test_size_w();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
